// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit common-anode 7-segment driver with tear-free frame commit
// Define SEG7_HEX_EN to render codes 10..15 as A..F; otherwise they are blank.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW:0]   BLANK_END = (CW+1)'(BLANK_CYCLES);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pdig_q, pdig_d, ddig_q, ddig_d;
  logic [NUM_DIGITS-1:0]   pdp_q, pdp_d, ddp_q, ddp_d;
  logic                    plz_q, plz_d, dlz_q, dlz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    slot_end, boundary, in_blank, zero_run;
  logic [NUM_DIGITS-1:0]   lz_mask, an_drive;
  logic [3:0]              cur_dig;
  logic                    cur_dp, cur_lz;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
`ifdef SEG7_HEX_EN
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      4'hF: decode = 7'b0001110;
`endif
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    boundary = slot_end && (idx_q == IDX_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    pdig_d = load ? digits_in : pdig_q;
    pdp_d  = load ? dp_in     : pdp_q;
    plz_d  = load ? lz_blank  : plz_q;
    ddig_d = ddig_q;
    ddp_d  = ddp_q;
    dlz_d  = dlz_q;
    // A load landing on the boundary edge goes straight to the display.
    if (boundary) begin
      ddig_d = pdig_d;
      ddp_d  = pdp_d;
      dlz_d  = plz_d;
    end

    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (ddig_q[4*i +: 4] == 4'h0);
      lz_mask[i] = dlz_q && zero_run;
    end

    cur_dig  = 4'h0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    an_drive = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_dig     = ddig_q[4*i +: 4];
        cur_dp      = ddp_q[i];
        cur_lz      = lz_mask[i];
        an_drive[i] = 1'b0;
      end
    end

    in_blank = ({1'b0, cnt_q} < BLANK_END);
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    an_d     = '1;
    if (!in_blank) begin
      an_d  = an_drive;
      seg_d = cur_lz ? 7'h7F : decode(cur_dig);
      dp_d  = ~cur_dp;
    end
    fd_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pdig_q <= '0;
      pdp_q  <= '0;
      plz_q  <= 1'b0;
      ddig_q <= '0;
      ddp_q  <= '0;
      dlz_q  <= 1'b0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      an_q   <= '1;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pdig_q <= pdig_d;
      pdp_q  <= pdp_d;
      plz_q  <= plz_d;
      ddig_q <= ddig_d;
      ddp_q  <= ddp_d;
      dlz_q  <= dlz_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 blank)
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg7_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t        sb[$];
  logic [6:0]  seg_tab [16];
  logic [15:0] m_pd, m_dd;
  logic [3:0]  m_pp, m_dp;
  logic        m_pl, m_dl;
  int          m_cnt, m_idx;
  int          n_vec = 0, n_err = 0, cyc = 0, last_fd = -1;
  logic [6:0]  last_seg [4];
  logic        last_dp [4];
  logic [3:0]  first_an;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pd = '0; m_dd = '0; m_pp = '0; m_dp = '0; m_pl = 0; m_dl = 0;
    m_cnt = 0; m_idx = 0;
  endtask

  task automatic step(input logic ld);
    exp_t e;
    logic bnd;
    @(negedge clk);
    load = ld;
    e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.fd = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      bnd = (m_cnt == 7) && (m_idx == 3);
      if (m_cnt >= 2) begin
        e.an  = ~(4'b0001 << m_idx);
        e.dp  = ~m_dp[m_idx];
        e.seg = (m_dl && m_idx > 0 && (m_dd >> (4 * m_idx)) == 16'h0)
                ? 7'h7F : seg_tab[m_dd[4*m_idx +: 4]];
      end
      e.fd = bnd;
      if (ld) begin
        m_pd = digits_in; m_pp = dp_in; m_pl = lz_blank;
      end
      if (bnd) begin
        m_dd = m_pd; m_dp = m_pp; m_dl = m_pl;
      end
      if (m_cnt == 7) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("seg", seg, e.seg);
    check("dp", dp, e.dp);
    check("an", an, e.an);
    check("frame_done", frame_done, e.fd);
    cyc++;
    for (int d = 0; d < 4; d++) begin
      if (an == ~(4'b0001 << d)) begin
        last_seg[d] = seg;
        last_dp[d]  = dp;
      end
    end
    if (first_an == 4'hF && an != 4'hF) first_an = an;
    if (frame_done) begin
      if (last_fd >= 0) check("fd_period", cyc - last_fd, 32);
      last_fd = cyc;
    end
  endtask

  task automatic run_fd(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < n * 32 + 40) begin
      step(1'b0);
      if (frame_done) seen++;
      guard++;
    end
    if (seen < n) check("fd_timeout", seen, n);
  endtask

  task automatic wait_state(input int c, input int i);
    int g = 0;
    while (!(m_cnt == c && m_idx == i) && g < 64) begin
      step(1'b0);
      g++;
    end
    if (!(m_cnt == c && m_idx == i)) check("state_timeout", 0, 1);
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 4; d++) begin
      last_seg[d] = 7'h55;
      last_dp[d]  = 1'bx;
    end
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000,
`ifdef SEG7_HEX_EN
                7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
                7'b0000110, 7'b0001110};
`else
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
    model_reset();
    clear_obs();
    first_an = 4'hF;

    // Reset state and free-running scan of zeros
    repeat (3) step(1'b0);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    rst_n = 1'b1;
    run_fd(2);
    for (int d = 0; d < 4; d++) check($sformatf("scan0_d%0d", d), last_seg[d], 7'b1000000);

    // Tear-free load mid-frame
    wait_state(3, 1);
    digits_in = 16'h1234; dp_in = 4'b0000; lz_blank = 1'b0;
    step(1'b1);
    clear_obs();
    run_fd(1);
    check("tear_old_d3", last_seg[3], 7'b1000000);
    clear_obs();
    run_fd(1);
    check("tear_d0", last_seg[0], 7'b0011001);
    check("tear_d1", last_seg[1], 7'b0110000);
    check("tear_d2", last_seg[2], 7'b0100100);
    check("tear_d3", last_seg[3], 7'b1111001);

    // Load on the boundary edge bypasses the pending buffer
    wait_state(7, 3);
    digits_in = 16'h0005;
    step(1'b1);
    check("byp_fd", frame_done, 1'b1);
    clear_obs();
    repeat (3) step(1'b0);
    check("byp_d0", last_seg[0], 7'b0010010);

    // Leading-zero blanking keeps the decimal point
    digits_in = 16'h0050; dp_in = 4'b1000; lz_blank = 1'b1;
    step(1'b1);
    clear_obs();
    run_fd(2);
    check("lz_d3", last_seg[3], 7'h7F);
    check("lz_dp3", last_dp[3], 1'b0);
    check("lz_d2", last_seg[2], 7'h7F);
    check("lz_d1", last_seg[1], 7'b0010010);
    check("lz_d0", last_seg[0], 7'b1000000);

    // Hex codes
    digits_in = 16'hABCF; dp_in = 4'b0000; lz_blank = 1'b0;
    step(1'b1);
    clear_obs();
    run_fd(2);
`ifdef SEG7_HEX_EN
    check("hex_d0", last_seg[0], 7'b0001110);
    check("hex_d3", last_seg[3], 7'b0001000);
`else
    for (int d = 0; d < 4; d++) check($sformatf("hex_d%0d", d), last_seg[d], 7'h7F);
`endif

    // Asynchronous reset mid-slot, between clock edges
    wait_state(5, 2);
    rst_n = 1'b0;
    #1;
    check("arst_seg", seg, 7'h7F);
    check("arst_dp", dp, 1'b1);
    check("arst_an", an, 4'hF);
    check("arst_fd", frame_done, 1'b0);
    repeat (2) step(1'b0);
    last_fd = -1;
    rst_n = 1'b1;
    first_an = 4'hF;
    clear_obs();
    run_fd(1);
    check("arst_first_an", first_an, 4'b1110);
    for (int d = 0; d < 4; d++) check($sformatf("arst_d%0d", d), last_seg[d], 7'b1000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display. It replaces per-digit combinational decoders in the clock display path. It accepts a packed BCD/hex digit word with decimal points and latches it into a pending buffer. At frame boundaries it commits the buffer to the display, which removes tearing. It scans one digit at a time with an anti-ghosting blank interval and optional leading-zero suppression.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8
- SLOT_CYCLES, 1000, clock cycles per digit slot; at least BLANK_CYCLES+1
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; may be 0
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- load  in  1  strobe: capture digits_in, dp_in and lz_blank into the pending buffer
- digits_in  in  4*NUM_DIGITS  packed digits; digit 0 (rightmost) in [3:0]
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- lz_blank  in  1  leading-zero blanking enable, captured with load
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  digit anodes, one-hot active-low
- frame_done  out  1  one-cycle pulse when a frame commits

## Operation
- State:
  - slot counter cnt, 0..SLOT_CYCLES-1
  - digit index idx, 0..NUM_DIGITS-1
  - pending buffer {pdig, pdp, plz}
  - display register {ddig, ddp, dlz}
- cnt increments every cycle. When cnt = SLOT_CYCLES-1, cnt wraps to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the edge where cnt = SLOT_CYCLES-1 and idx = NUM_DIGITS-1. On that edge the pending buffer is copied to the display register.
- load = 1 on any edge: the pending buffer takes the inputs.
  - If load coincides with a frame boundary, the display register takes the newly loaded inputs directly (bypass), not the old pending buffer.
  - Multiple loads within a frame: the last one wins.
- Blank phase, cnt < BLANK_CYCLES: an = all ones, seg = 7'h7F, dp = 1.
- Drive phase: an[idx] = 0 and all other anodes = 1. seg = decode(ddig[idx]), dp = ~ddp[idx].
- Leading-zero blanking: with dlz = 1, digit i > 0 is blanked when digits i..NUM_DIGITS-1 are all zero. A blanked digit drives seg = 7'h7F but keeps its dp. Digit 0 is never blanked. The anode is still driven for a blanked digit.
- Decode codes, {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Codes 10..15 are defined under Configuration.

## Timing
- seg, dp, an and frame_done are registered. Each reflects the cnt/idx/display state of the preceding cycle, i.e. a one-cycle lag.
- Frame period is NUM_DIGITS*SLOT_CYCLES cycles. Each digit is lit for SLOT_CYCLES-BLANK_CYCLES cycles per frame.
- Load-to-display latency ranges from 1 cycle (load on a boundary) to NUM_DIGITS*SLOT_CYCLES cycles.
- frame_done is high for exactly the one cycle following each frame-boundary edge. It never stays high for two consecutive cycles.
- Reset values:
  - cnt = 0, idx = 0, all buffers = 0
  - seg = 7'h7F, dp = 1, an = all ones, frame_done = 0
- Reset asserted mid-slot returns all state and outputs to reset values immediately. Pending data is lost.
- After rst_n deasserts, the first frame displays all zeros. Data loaded during the first frame appears at the first boundary.

## Configuration
- SEG7_HEX_EN defined: codes 10..15 render A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- SEG7_HEX_EN undefined: codes 10..15 render blank, 1111111, in both drive phase and blanking logic. A code ≥ 10 counts as non-zero for leading-zero purposes.

## Test plan
All scenarios use NUM_DIGITS = 4, SLOT_CYCLES = 8, BLANK_CYCLES = 2.
- Reset/scan:
  - Stimulus: release rst_n, no load.
  - Required: an cycles through 1110, 1101, 1011, 0111, each low for 6 of 8 cycles with 1111 for 2. seg = 1000000 in every drive phase. frame_done pulses every 32 cycles.
- Tear-free load:
  - Stimulus: load digits_in = 16'h1234 mid-frame.
  - Required: the current frame still shows 0000. The next frame shows 4, 3, 2, 1 on digits 0..3 with seg = 0011001, 0110000, 0100100, 1111001. Update coincides with the frame_done pulse.
- Boundary bypass:
  - Stimulus: load 16'h0005 on the frame-boundary edge.
  - Required: the next digit-0 drive phase shows 0010010, with no one-frame delay.
- Leading zeros:
  - Stimulus: load 16'h0050 with lz_blank = 1 and dp_in = 4'b1000.
  - Required: digits 3 and 2 show seg = 1111111 with the digit-3 dp = 0. Digit 1 shows 0010010 and digit 0 shows 1000000.
- Hex mode:
  - Stimulus: load 16'hABCF.
  - With SEG7_HEX_EN: digit 0 = 0001110 and digit 3 = 0001000.
  - Without SEG7_HEX_EN: all four digits = 1111111.
- Async reset mid-frame:
  - Stimulus: assert rst_n low at cnt = 5, idx = 2.
  - Required: outputs go to reset values without waiting for a clock edge. After release, display = 0000 and scan restarts at idx = 0.
